// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter: round-robin AR grant into a single host AR slot,
// combinational R routing on m_rid[0], per-requester outstanding-burst tracking.
module axi_rd_arbiter #(
    parameter int ADDR_W  = 48,
    parameter int DATA_W  = 512,
    parameter int ID_W    = 4,
    parameter int MAX_OUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        s_arvalid,
    output logic [1:0]        s_arready,
    input  logic [ADDR_W-1:0] s_araddr [2],
    input  logic [7:0]        s_arlen  [2],
    input  logic [2:0]        s_arsize [2],
    output logic [1:0]        s_rvalid,
    input  logic [1:0]        s_rready,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [ID_W-1:0]   m_arid,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [ID_W-1:0]   m_rid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    output logic [7:0]        outstanding [2],
    output logic              err_unexpected
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t     state;
    logic       last_gnt;
    logic [1:0] elig;
    logic [1:0] gnt;
    logic       gnt_idx;
    logic       r_sel;
    logic       r_hs;
    logic       r_done;
    logic       unused_rid;

    // Saturating counter step; a decrement at zero is dropped so a concurrent
    // grant still gets counted.
    function automatic logic [7:0] cnt_next(input logic [7:0] cnt, input logic inc,
                                            input logic dec);
        logic dec_eff;
        dec_eff = dec && (cnt != 8'd0);
        if (inc && !dec_eff && (cnt < 8'(MAX_OUT)))
            return cnt + 8'd1;
        else if (dec_eff && !inc)
            return cnt - 8'd1;
        else
            return cnt;
    endfunction

    always_comb begin
        elig[0] = s_arvalid[0] && (outstanding[0] < 8'(MAX_OUT));
        elig[1] = s_arvalid[1] && (outstanding[1] < 8'(MAX_OUT));
        gnt_idx = (elig == 2'b11) ? ~last_gnt : elig[1];
        gnt     = 2'b00;
        if (reset_n && (state == IDLE) && (elig != 2'b00))
            gnt[gnt_idx] = 1'b1;
    end

    assign s_arready = gnt;

    // R path is pure routing; only bit 0 of the ID selects the requester.
    assign r_sel      = m_rid[0];
    assign unused_rid = ^m_rid;
    assign s_rvalid   = {m_rvalid & r_sel, m_rvalid & ~r_sel};
    assign m_rready   = s_rready[r_sel];
    assign s_rdata    = m_rdata;
    assign s_rresp    = m_rresp;
    assign s_rlast    = m_rlast;
    assign r_hs       = m_rvalid & m_rready;
    assign r_done     = r_hs & m_rlast;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            m_arvalid <= 1'b0;
            m_araddr  <= '0;
            m_arlen   <= '0;
            m_arsize  <= '0;
            m_arid    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt != 2'b00) begin
                        m_araddr  <= s_araddr[gnt_idx];
                        m_arlen   <= s_arlen[gnt_idx];
                        m_arsize  <= s_arsize[gnt_idx];
                        m_arid    <= ID_W'(gnt_idx);
                        last_gnt  <= gnt_idx;
                        m_arvalid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            outstanding[0] <= 8'd0;
            outstanding[1] <= 8'd0;
            err_unexpected <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++)
                outstanding[i] <= cnt_next(outstanding[i], gnt[i], r_done && (r_sel == 1'(i)));
            if (r_hs && (outstanding[r_sel] == 8'd0))
                err_unexpected <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios followed by randomized traffic,
// all checked each cycle against a behavioural model of the arbiter rules.
module tb_axi_rd_arbiter;

    localparam int ADDR_W  = 48;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 4;
    localparam int MAX_OUT = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        s_arvalid;
    logic [1:0]        s_arready;
    logic [ADDR_W-1:0] s_araddr [2];
    logic [7:0]        s_arlen  [2];
    logic [2:0]        s_arsize [2];
    logic [1:0]        s_rvalid;
    logic [1:0]        s_rready;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;
    logic              m_arvalid;
    logic              m_arready;
    logic [ADDR_W-1:0] m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [ID_W-1:0]   m_arid;
    logic              m_rvalid;
    logic              m_rready;
    logic [ID_W-1:0]   m_rid;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;
    logic [7:0]        outstanding [2];
    logic              err_unexpected;

    axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arid(m_arid),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast),
        .outstanding(outstanding), .err_unexpected(err_unexpected)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: per-requester burst counts, who was granted last,
    // the burst currently offered to the host, and the sticky error.
    int                mcnt [2];
    int                mlast;
    bit                mpend;
    logic [ADDR_W-1:0] maddr;
    logic [7:0]        mlen;
    logic [2:0]        msize;
    int                mid;
    bit                merr;
    logic [1:0]        seen_arready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mcnt[0] = 0;
        mcnt[1] = 0;
        mlast   = 1;
        mpend   = 1'b0;
        maddr   = '0;
        mlen    = '0;
        msize   = '0;
        mid     = 0;
        merr    = 1'b0;
    endtask

    task automatic idle_inputs();
        s_arvalid = 2'b00;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rid     = '0;
        m_rlast   = 1'b0;
        s_rready  = 2'b00;
        m_rdata   = '0;
        m_rresp   = 2'b00;
    endtask

    // One clock: check every output against the model just before the edge,
    // advance the model by the edge, return #1 after the edge.
    task automatic cycle();
        logic [1:0] el;
        logic [1:0] exp_rdy;
        int         g;
        int         sel;
        bit         hs;
        int         inc;
        int         dec;
        @(negedge clk);
        el      = 2'b00;
        exp_rdy = 2'b00;
        g       = -1;
        for (int i = 0; i < 2; i++)
            el[i] = s_arvalid[i] && (mcnt[i] < MAX_OUT);
        if (reset_n && !mpend && (el != 2'b00)) begin
            g = (el == 2'b11) ? (1 - mlast) : (el[1] ? 1 : 0);
            exp_rdy[g] = 1'b1;
        end
        sel = m_rid[0] ? 1 : 0;
        seen_arready = s_arready;
        chk("s_arready", 64'(s_arready), 64'(exp_rdy));
        chk("s_rvalid", 64'(s_rvalid), m_rvalid ? (sel == 1 ? 64'd2 : 64'd1) : 64'd0);
        chk("m_rready", 64'(m_rready), 64'(s_rready[sel]));
        chk("r_passthru", 64'({s_rdata, s_rresp, s_rlast}), 64'({m_rdata, m_rresp, m_rlast}));
        chk("m_arvalid", 64'(m_arvalid), 64'(mpend));
        if (mpend) begin
            chk("m_ar_fields", 64'({m_araddr, m_arlen, m_arsize}), 64'({maddr, mlen, msize}));
            chk("m_arid", 64'(m_arid), 64'(mid));
        end
        chk("outstanding0", 64'(outstanding[0]), 64'(mcnt[0]));
        chk("outstanding1", 64'(outstanding[1]), 64'(mcnt[1]));
        chk("err_unexpected", 64'(err_unexpected), 64'(merr));

        if (!reset_n) begin
            model_reset();
        end else begin
            hs = m_rvalid && s_rready[sel];
            if (hs && mcnt[sel] == 0)
                merr = 1'b1;
            for (int i = 0; i < 2; i++) begin
                inc = (g == i) ? 1 : 0;
                dec = (hs && m_rlast && sel == i && mcnt[i] > 0) ? 1 : 0;
                mcnt[i] = mcnt[i] + inc - dec;
            end
            if (g >= 0) begin
                mpend = 1'b1;
                maddr = s_araddr[g];
                mlen  = s_arlen[g];
                msize = s_arsize[g];
                mid   = g;
                mlast = g;
            end else if (mpend && m_arready) begin
                mpend = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        int n0;
        int n1;
        int gq[$];
        int iq[$];

        model_reset();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            s_araddr[i] = '0;
            s_arlen[i]  = '0;
            s_arsize[i] = '0;
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_araddr", 64'(m_araddr), 64'd0);
        chk("rst_arlen_size_id", 64'({m_arlen, m_arsize, m_arid}), 64'd0);
        chk("rst_arvalid", 64'(m_arvalid), 64'd0);

        // Single request from requester 1, then four beats back with extra ID bits set.
        s_arvalid      = 2'b10;
        s_araddr[1]    = 48'h1000;
        s_arlen[1]     = 8'd3;
        s_arsize[1]    = 3'd6;
        m_arready      = 1'b1;
        cycle();
        chk("r020_grant", 64'(seen_arready), 64'd2);
        s_arvalid = 2'b00;
        chk("r020_arvalid", 64'(m_arvalid), 64'd1);
        chk("r020_araddr", 64'(m_araddr), 64'h1000);
        chk("r020_arlen", 64'(m_arlen), 64'd3);
        chk("r020_arid", 64'(m_arid), 64'd1);
        chk("r020_out1", 64'(outstanding[1]), 64'd1);
        cycle();
        for (int k = 0; k < 4; k++) begin
            m_rvalid = 1'b1;
            m_rid    = 4'b1011;
            m_rdata  = 32'hC0DE_0000 + 32'(k);
            s_rready = 2'b10;
            m_rlast  = (k == 3);
            cycle();
        end
        idle_inputs();
        chk("r020_out1_done", 64'(outstanding[1]), 64'd0);
        chk("r020_no_err", 64'(err_unexpected), 64'd0);

        // Both requesters held valid: strict alternation until both hit MAX_OUT.
        do_reset();
        s_arvalid   = 2'b11;
        s_araddr[0] = 48'hA000;
        s_araddr[1] = 48'hB000;
        m_arready   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (seen_arready != 2'b00) begin
                gq.push_back(seen_arready[1] ? 1 : 0);
                iq.push_back(int'(m_arid));
            end
        end
        chk("r021_ngrants", 64'(gq.size()), 64'd4);
        for (int k = 0; k < 4 && k < gq.size(); k++) begin
            chk("r021_grant_seq", 64'(gq[k]), 64'(k % 2));
            chk("r021_arid_seq", 64'(iq[k]), 64'(k % 2));
        end
        idle_inputs();

        // Host back-pressure holds the burst and blocks further grants.
        do_reset();
        s_arvalid   = 2'b01;
        s_araddr[0] = 48'hABC0;
        m_arready   = 1'b0;
        cycle();
        s_arvalid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            s_araddr[0] = ADDR_W'({$urandom, $urandom});
            s_araddr[1] = ADDR_W'({$urandom, $urandom});
            cycle();
            chk("r022_no_grant", 64'(seen_arready), 64'd0);
            chk("r022_hold_addr", 64'(m_araddr), 64'hABC0);
            chk("r022_hold_valid", 64'(m_arvalid), 64'd1);
        end
        m_arready = 1'b1;
        cycle();
        cycle();
        chk("r022_next_grant", 64'(seen_arready), 64'd2);
        chk("r022_next_arid", 64'(m_arid), 64'd1);
        idle_inputs();

        // Requester 0 saturates at MAX_OUT; requester 1 still served.
        do_reset();
        s_arvalid = 2'b01;
        m_arready = 1'b1;
        n0 = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            n0 += int'(seen_arready[0]);
        end
        chk("r023_grants0", 64'(n0), 64'd2);
        chk("r023_out0", 64'(outstanding[0]), 64'd2);
        s_arvalid = 2'b11;
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            n0 += int'(seen_arready[0]);
            n1 += int'(seen_arready[1]);
        end
        chk("r023_blocked0", 64'(n0), 64'd0);
        chk("r023_grant1", 64'(n1), 64'd1);
        idle_inputs();

        // Grant and last beat for the same requester in one cycle.
        do_reset();
        s_arvalid = 2'b01;
        m_arready = 1'b1;
        cycle();
        s_arvalid = 2'b00;
        cycle();
        chk("r024_pre", 64'(outstanding[0]), 64'd1);
        s_arvalid = 2'b01;
        m_rvalid  = 1'b1;
        m_rid     = '0;
        m_rlast   = 1'b1;
        s_rready  = 2'b01;
        cycle();
        chk("r024_grant", 64'(seen_arready), 64'd1);
        chk("r024_out0", 64'(outstanding[0]), 64'd1);
        chk("r024_no_err", 64'(err_unexpected), 64'd0);
        idle_inputs();
        m_arready = 1'b1;

        // Unexpected beat sets a sticky error cleared only by reset.
        m_rvalid = 1'b1;
        m_rid    = 4'b0001;
        m_rlast  = 1'b1;
        s_rready = 2'b10;
        cycle();
        idle_inputs();
        chk("r025_err_set", 64'(err_unexpected), 64'd1);
        for (int k = 0; k < 3; k++)
            cycle();
        chk("r025_err_held", 64'(err_unexpected), 64'd1);
        do_reset();
        chk("r025_err_clr", 64'(err_unexpected), 64'd0);
        chk("r025_cnt_clr", 64'({outstanding[0], outstanding[1]}), 64'd0);

        // Randomized traffic, including occasional resets mid-burst.
        for (int k = 0; k < 3000; k++) begin
            reset_n   = ($urandom_range(0, 99) != 0);
            s_arvalid = 2'($urandom);
            for (int i = 0; i < 2; i++) begin
                s_araddr[i] = ADDR_W'({$urandom, $urandom});
                s_arlen[i]  = 8'($urandom);
                s_arsize[i] = 3'($urandom);
            end
            m_arready = ($urandom_range(0, 3) != 0);
            m_rvalid  = ($urandom_range(0, 1) != 0);
            m_rid     = ID_W'($urandom);
            m_rdata   = $urandom;
            m_rresp   = 2'($urandom);
            m_rlast   = ($urandom_range(0, 2) == 0);
            s_rready  = 2'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
